// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
`timescale 1ns/1ps
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    localparam int         DIGITS_DEF = 3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] NIB_THRESH = 4'd8;
    localparam logic [3:0] NIB_CORR   = 4'd3;

endpackage

// File: rtl/module_bcd_nibfix.sv
// Reverse double-dabble correction for one BCD nibble.
`timescale 1ns/1ps
module module_bcd_nibfix
    import bcd_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    assign nib_out = (nib_in >= NIB_THRESH) ? (nib_in - NIB_CORR) : nib_in;

endmodule

// File: rtl/module_bcd2bin.sv
// Sequential signed BCD-to-binary converter with range and digit checking.
`timescale 1ns/1ps
module module_bcd2bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = 8
) (
    input  logic                  clk_div,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  neg,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int MAG_W = $clog2(10 ** DIGITS);
    localparam int ITER  = MAG_W;
    localparam int SR_W  = BCD_W + MAG_W;
    localparam int CNT_W = $clog2(ITER + 1);

    localparam logic [MAG_W:0] POS_LIM = (MAG_W+1)'((2 ** (BIN_W - 1)) - 1);
    localparam logic [MAG_W:0] NEG_LIM = (MAG_W+1)'(2 ** (BIN_W - 1));

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_sh;
    logic [SR_W-1:0]    sr_nxt;
    logic [BCD_W-1:0]   fix_bcd;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q;
    logic               bad_q;
    logic [DIGITS-1:0]  bad_vec;
    logic [MAG_W:0]     mag_w;
    logic               ovf;
    logic [BIN_W:0]     mag_x;
    logic [BIN_W:0]     res_full;

    assign sr_sh = sr >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        module_bcd_nibfix u_fix (
            .nib_in  (sr_sh[MAG_W + 4*g +: 4]),
            .nib_out (fix_bcd[4*g +: 4])
        );
        assign bad_vec[g] = bcd_in[4*g +: 4] > BCD_MAX;
    end

    assign sr_nxt = {fix_bcd, sr_sh[MAG_W-1:0]};

    // Range check on an unsigned magnitude one bit wider than the bin field
    assign mag_w    = {1'b0, sr[MAG_W-1:0]};
    assign ovf      = neg_q ? (mag_w > NEG_LIM) : (mag_w > POS_LIM);
    assign mag_x    = (BIN_W+1)'(sr[MAG_W-1:0]);
    assign res_full = neg_q ? (~mag_x + 1'b1) : mag_x;

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            bad_q   <= 1'b0;
            bin_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= {bcd_in, MAG_W'(0)};
                        neg_q <= neg;
                        bad_q <= |bad_vec;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(ITER - 1))
                        state <= FINISH;
                end
                FINISH: begin
                    err     <= bad_q | ovf;
                    bin_out <= (bad_q | ovf) ? '0 : BIN_W'(res_full);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
